// File: rtl/pwm_pkg.sv
// Shared constants and compare helper for the PWM peripheral.
// Latency: none (definitions only).
// Backpressure: none.
package pwm_pkg;
    localparam int PWM_CNT_W       = 8;
    localparam int N_CHANNELS      = 16;
    localparam int CLK_DIV_DEFAULT = 13;

    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam logic [PWM_CNT_W-1:0] CNT_MAX   = 8'hFF;

    // Full-scale duty is forced high so count 255 cannot produce a one-count dip.
    function automatic logic pwm_level_f(input logic [PWM_CNT_W-1:0] cnt,
                                         input logic [PWM_CNT_W-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction
endpackage

// File: rtl/pwm_timebase.sv
// Prescaled free-running 8-bit PWM counter with period-boundary strobe.
// Latency: period_start registered one clk after the boundary cycle.
// Backpressure: none, free-runs out of reset.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_CNT_W-1:0] pwm_cnt,
    output logic                 boundary,
    output logic                 period_start
);
    localparam int              DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]     div_cnt_d, div_cnt_q;
    logic [PWM_CNT_W-1:0] pwm_cnt_d, pwm_cnt_q;
    logic                 period_start_d, period_start_q;
    logic                 tick;

    always_comb begin
        tick           = (div_cnt_q == DIV_MAX);
        div_cnt_d      = tick ? '0 : div_cnt_q + DIV_W'(1);
        // 255 -> 0 wrap comes from natural 8-bit overflow.
        pwm_cnt_d      = tick ? pwm_cnt_q + PWM_CNT_W'(1) : pwm_cnt_q;
        boundary       = tick && (pwm_cnt_q == CNT_MAX);
        period_start_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_cnt      = pwm_cnt_q;
    assign period_start = period_start_q;
endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM output stage; PWM_SHADOW_EN shadows the duty at period boundaries.
// Latency: one clk from enables/count to out.
// Backpressure: none.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            en_reg_out_7_0,
    input  logic [7:0]            en_reg_out_15_8,
    input  logic [7:0]            en_reg_pwm_7_0,
    input  logic [7:0]            en_reg_pwm_15_8,
    input  logic [7:0]            pwm_duty_cycle,
    output logic [N_CHANNELS-1:0] out,
    output logic                  period_start
);
    logic [PWM_CNT_W-1:0]  pwm_cnt;
    logic                  boundary;
    logic [PWM_CNT_W-1:0]  duty_eff;
    logic                  pwm_level;
    logic [N_CHANNELS-1:0] en_out, en_pwm;
    logic [N_CHANNELS-1:0] out_d, out_q;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_cnt      (pwm_cnt),
        .boundary     (boundary),
        .period_start (period_start)
    );

`ifdef PWM_SHADOW_EN
    logic [PWM_CNT_W-1:0] duty_shadow_d, duty_shadow_q;

    // Duty written on the boundary edge itself is captured for the new period.
    always_comb begin
        duty_shadow_d = duty_shadow_q;
        if (boundary) duty_shadow_d = pwm_duty_cycle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) duty_shadow_q <= '0;
        else        duty_shadow_q <= duty_shadow_d;
    end

    assign duty_eff = duty_shadow_q;
`else
    logic unused_boundary;
    assign unused_boundary = boundary;
    assign duty_eff        = pwm_duty_cycle;
`endif

    always_comb begin
        en_out    = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        pwm_level = pwm_level_f(pwm_cnt, duty_eff);
        out_d     = en_out & (~en_pwm | {N_CHANNELS{pwm_level}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end

    assign out = out_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral at CLK_DIV = 13 (period 3328 clks).
module tb_pwm_peripheral;
    localparam int P    = 3328;
    localparam int HALF = 1664;

    logic        clk;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    int n_pass  = 0;
    int n_total = 0;

    pwm_peripheral #(
        .CLK_DIV (13)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        en_reg_out_7_0  = eo[7:0];
        en_reg_out_15_8 = eo[15:8];
        en_reg_pwm_7_0  = ep[7:0];
        en_reg_pwm_15_8 = ep[15:8];
    endtask

    // Waits (bounded) for a period_start pulse, sampled on negedges.
    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * P + 16; i++) begin
            @(negedge clk);
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Observes one period: out[0] high count, first low sample, first period_start sample.
    task automatic measure_period(output int highs, output int first_low, output int ps_at);
        highs = 0; first_low = 0; ps_at = 0;
        for (int k = 1; k <= P; k++) begin
            @(negedge clk);
            if (out[0] === 1'b1) highs++;
            else if (first_low == 0) first_low = k;
            if (period_start === 1'b1 && ps_at == 0) ps_at = k;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_en(16'hFFFF, 16'h0000);
        pwm_duty_cycle = 8'h00;
        repeat (3) @(negedge clk);
        n_total++;
        if (out !== 16'h0000) $display("FAIL reset_out: got %h expected 0000", out);
        else n_pass++;
        n_total++;
        if (period_start !== 1'b0) $display("FAIL reset_period_start: got %b expected 0", period_start);
        else n_pass++;
        set_en(16'h0000, 16'h0000);
        rst_n = 1'b1;
    endtask

    task automatic test_static;
        set_en(16'hFFFF, 16'h0000);
        @(negedge clk);
        n_total++;
        if (out !== 16'hFFFF) $display("FAIL static_all: got %h expected FFFF", out);
        else n_pass++;
        set_en(16'h00F0, 16'h0000);
        @(negedge clk);
        n_total++;
        if (out !== 16'h00F0) $display("FAIL static_00f0: got %h expected 00F0", out);
        else n_pass++;
    endtask

    task automatic test_half_duty;
        bit ok;
        int highs, first_low, ps_at;
        set_en(16'h0001, 16'h0001);
        pwm_duty_cycle = 8'h80;
        wait_ps(ok);
        n_total++;
        if (!ok) $display("FAIL half_wait_ps: got timeout expected period_start");
        else n_pass++;
        measure_period(highs, first_low, ps_at);
        n_total++;
        if (highs !== HALF) $display("FAIL half_high_clks: got %0d expected %0d", highs, HALF);
        else n_pass++;
        n_total++;
        if (first_low !== HALF + 1) $display("FAIL half_first_low: got %0d expected %0d", first_low, HALF + 1);
        else n_pass++;
        n_total++;
        if (ps_at !== P) $display("FAIL half_period_spacing: got %0d expected %0d", ps_at, P);
        else n_pass++;
    endtask

    task automatic test_extremes;
        bit ok;
        int highs, first_low, ps_at, sum;
        pwm_duty_cycle = 8'h00;
        wait_ps(ok);
        sum = 0;
        for (int p = 0; p < 3; p++) begin
            measure_period(highs, first_low, ps_at);
            sum += highs;
        end
        n_total++;
        if (!ok || sum !== 0) $display("FAIL duty00_highs: got %0d expected 0 (ps_seen=%0b)", sum, ok);
        else n_pass++;

        pwm_duty_cycle = 8'hFF;
        wait_ps(ok);
        sum = 0;
        for (int p = 0; p < 3; p++) begin
            measure_period(highs, first_low, ps_at);
            sum += highs;
        end
        n_total++;
        if (!ok || sum !== 3 * P) $display("FAIL dutyff_highs: got %0d expected %0d (ps_seen=%0b)", sum, 3 * P, ok);
        else n_pass++;

        set_en(16'h0001, 16'h0021);
        @(negedge clk);
        n_total++;
        if (out !== 16'h0001) $display("FAIL pwm_without_out_en: got %h expected 0001", out);
        else n_pass++;
    endtask

    task automatic test_shadow;
        bit ok;
        int highs, first_low, ps_at, exp_first;
        set_en(16'h0001, 16'h0001);
        pwm_duty_cycle = 8'h40;
        wait_ps(ok);
        highs = 0; ps_at = 0;
        for (int k = 1; k <= P; k++) begin
            @(negedge clk);
            if (k == 32 * 13) pwm_duty_cycle = 8'hC0;
            if (out[0] === 1'b1) highs++;
            if (period_start === 1'b1 && ps_at == 0) ps_at = k;
        end
`ifdef PWM_SHADOW_EN
        exp_first = 832;
`else
        exp_first = 2496;
`endif
        n_total++;
        if (!ok || highs !== exp_first) $display("FAIL shadow_cur_period: got %0d expected %0d (ps_seen=%0b)", highs, exp_first, ok);
        else n_pass++;
        measure_period(highs, first_low, ps_at);
        n_total++;
        if (highs !== 2496) $display("FAIL shadow_next_period: got %0d expected 2496", highs);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int highs, first_low, ps_at, exp_highs;
        set_en(16'hFFFF, 16'h0000);
        repeat (2) @(negedge clk);
        n_total++;
        if (out !== 16'hFFFF) $display("FAIL pre_reset_out: got %h expected FFFF", out);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (out !== 16'h0000) $display("FAIL async_reset_out: got %h expected 0000", out);
        else n_pass++;
        set_en(16'h0001, 16'h0001);
        pwm_duty_cycle = 8'h80;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure_period(highs, first_low, ps_at);
`ifdef PWM_SHADOW_EN
        exp_highs = 0;
`else
        exp_highs = HALF;
`endif
        n_total++;
        if (highs !== exp_highs) $display("FAIL first_period_highs: got %0d expected %0d", highs, exp_highs);
        else n_pass++;
        n_total++;
        if (ps_at !== P) $display("FAIL first_period_start: got %0d expected %0d", ps_at, P);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_static;
        test_half_duty;
        test_extremes;
        test_shadow;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Multi-channel PWM generator sitting directly downstream of the SPI register block. It consumes the five 8-bit control registers written over SPI (output enables, PWM-mode enables, duty cycle). It drives 16 user outputs, each forced low, forced high, or toggled by a shared 8-bit PWM waveform. The prescaled timebase sets a period of 256 × CLK_DIV clk cycles; the default is about 3 kHz at 10 MHz.

## Interface
- CLK_DIV, 13, clk cycles per PWM count step; legal range ≥1
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en_reg_out_7_0  in  8  output enable, channels 7..0
- en_reg_out_15_8  in  8  output enable, channels 15..8
- en_reg_pwm_7_0  in  8  PWM-mode select, channels 7..0
- en_reg_pwm_15_8  in  8  PWM-mode select, channels 15..8
- pwm_duty_cycle  in  8  shared duty value; 0x00 = 0 %, 0xFF = 100 %
- out  out  16  registered channel outputs
- period_start  out  1  one-clk pulse marking count 0 of each PWM period

## Operation
- Prescaler div_cnt:
  - counts 0..CLK_DIV-1 and wraps to 0.
  - Asserts tick when div_cnt == CLK_DIV-1.
  - With CLK_DIV = 1, tick is asserted every cycle.
- PWM counter pwm_cnt:
  - 8-bit, increments on tick, wraps 255→0 unconditionally.
  - There is no idle state; the counter free-runs out of reset.
- Period boundary is tick && pwm_cnt == 255. At that edge:
  - pwm_cnt becomes 0.
  - period_start is registered high for exactly one clk.
  - duty_shadow loads pwm_duty_cycle (see Configuration).
- PWM level, with duty_eff the effective duty:
  - pwm_level = (duty_eff == 0xFF) | (pwm_cnt < duty_eff).
  - duty 0x00 gives a constant low; 0xFF gives a constant high with no one-count glitch.
  - For 1..254, the output is high for duty_eff × CLK_DIV clks per period.
- Per channel i, en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - en_out[i] = 0 → out[i] = 0, regardless of en_pwm[i].
  - en_out[i] = 1, en_pwm[i] = 0 → out[i] = 1 (static high).
  - en_out[i] = 1, en_pwm[i] = 1 → out[i] = pwm_level.
- All 16 PWM channels share one pwm_level, so they are phase-aligned.
- Enable inputs are used directly and are not shadowed. Enable changes take effect mid-period.
- Inputs are already synchronous to clk, because the upstream block is on the same clock. No synchronizers are used.

## Timing
- Reset values: out = 0x0000, period_start = 0, div_cnt = 0, pwm_cnt = 0, duty_shadow = 0x00.
- Reset is asynchronous. Asserting it mid-period clears out in the same instant, without waiting for clk.
- First period after reset release:
  - duty_shadow = 0, so PWM-mode channels stay low until the first boundary.
  - With the shadow enabled, this lasts 256 × CLK_DIV clks.
- out latency: one clk from any change in en_* or pwm_cnt to out.
- period_start rises on the same edge on which pwm_cnt becomes 0. That edge occurs one clk before out reflects count 0.
- Duty change:
  - Takes effect at the next period boundary (shadow enabled).
  - The in-flight period completes with the old duty.
- Simultaneous duty write and boundary edge: the new value is loaded; the input is sampled at that edge.
- Period length: exactly 256 × CLK_DIV clks. div_cnt width is max(1, $clog2(CLK_DIV)).

## Configuration
- PWM_SHADOW_EN defined:
  - duty_eff = duty_shadow, updated only at the period boundary.
  - This gives glitch-free duty transitions.
- PWM_SHADOW_EN undefined:
  - duty_eff = pwm_duty_cycle, used combinationally.
  - No shadow register exists.
  - A mid-period write changes the compare immediately, so a truncated or extended pulse within that period is permitted.
  - The first period after reset uses the live input.

## Structure
- Package pwm_pkg holds:
  - PWM_CNT_W = 8
  - DUTY_FULL = 8'hFF
  - N_CHANNELS = 16
  - CLK_DIV_DEFAULT = 13
- Sub-module pwm_timebase contains the prescaler, pwm_cnt and period_start generation. Outputs: pwm_cnt, boundary, period_start.
- The top level contains the shadow register, the compare and the 16-channel output mux/register.

## Test plan
- Reset: hold rst_n low → out == 0x0000 and period_start == 0. Assert rst_n mid-period with out == 0xFFFF → out == 0 immediately.
- Static outputs: en_out = 0xFFFF, en_pwm = 0x0000 → out == 0xFFFF one clk later. Set en_out = 0x00F0 → out == 0x00F0.
- 50 % duty, CLK_DIV = 13: en_out[0] = en_pwm[0] = 1, duty = 0x80. After the first period_start, out[0] is high 1664 clks then low 1664 clks. period_start pulses are spaced 3328 clks apart.
- Extremes:
  - duty 0x00 → out[0] constantly 0 across 3 periods.
  - duty 0xFF → constantly 1 with no low cycle.
  - en_pwm[5] = 1 with en_out[5] = 0 → out[5] == 0.
- Shadowing (PWM_SHADOW_EN): duty 0x40, then write 0xC0 at pwm_cnt = 0x20. The current high pulse still ends after 832 clks. The next period is high for 2496 clks.
- Same stimulus without PWM_SHADOW_EN: the high pulse extends until pwm_cnt reaches 0xC0 within the current period.
